// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: note indices, ROM entry layout,
// FSM state encoding and the note-to-divisor conversion.
package note_sequencer_pkg;

    localparam int NOTE_W  = 6;
    localparam int BEATS_W = 3;
    localparam int ENTRY_W = NOTE_W + BEATS_W;
    localparam int DIVX_W  = 32;

    // Note indices: 0 is a rest, 1..36 run chromatically from C4 to B6
    localparam logic [NOTE_W-1:0] REST = 6'd0;
    localparam logic [NOTE_W-1:0] C4   = 6'd1;
    localparam logic [NOTE_W-1:0] D4   = 6'd3;
    localparam logic [NOTE_W-1:0] E4   = 6'd5;
    localparam logic [NOTE_W-1:0] F4   = 6'd6;
    localparam logic [NOTE_W-1:0] G4   = 6'd8;
    localparam logic [NOTE_W-1:0] A4   = 6'd10;
    localparam logic [NOTE_W-1:0] B4   = 6'd12;
    localparam logic [NOTE_W-1:0] C5   = 6'd13;
    localparam logic [NOTE_W-1:0] D5   = 6'd15;
    localparam logic [NOTE_W-1:0] E5   = 6'd17;
    localparam logic [NOTE_W-1:0] F5   = 6'd18;
    localparam logic [NOTE_W-1:0] G5   = 6'd20;
    localparam logic [NOTE_W-1:0] A5   = 6'd22;
    localparam logic [NOTE_W-1:0] B5   = 6'd24;
    localparam logic [NOTE_W-1:0] C6   = 6'd25;
    localparam logic [NOTE_W-1:0] D6   = 6'd27;
    localparam logic [NOTE_W-1:0] E6   = 6'd29;
    localparam logic [NOTE_W-1:0] F6   = 6'd30;
    localparam logic [NOTE_W-1:0] G6   = 6'd32;
    localparam logic [NOTE_W-1:0] A6   = 6'd34;
    localparam logic [NOTE_W-1:0] B6   = 6'd36;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EVAL,
        ST_NOTE,
        ST_GAP
    } seq_state_t;

    // Short demo tune (entry 0 in the low bits); beats == 0 terminates it
    localparam logic [8*ENTRY_W-1:0] DEMO_SONG = {
        {REST, 3'd0}, {C5, 3'd2}, {G4, 3'd1}, {REST, 3'd1},
        {C5, 3'd2},   {G4, 3'd1}, {E4, 3'd1}, {C4, 3'd1}
    };

    // Equal-tempered note frequency in millihertz, 0 for rest/out of range
    function automatic logic [31:0] note_mhz(input logic [NOTE_W-1:0] note);
        case (note)
            6'd1:  return 32'd261626;
            6'd2:  return 32'd277183;
            6'd3:  return 32'd293665;
            6'd4:  return 32'd311127;
            6'd5:  return 32'd329628;
            6'd6:  return 32'd349228;
            6'd7:  return 32'd369994;
            6'd8:  return 32'd391995;
            6'd9:  return 32'd415305;
            6'd10: return 32'd440000;
            6'd11: return 32'd466164;
            6'd12: return 32'd493883;
            6'd13: return 32'd523251;
            6'd14: return 32'd554365;
            6'd15: return 32'd587330;
            6'd16: return 32'd622254;
            6'd17: return 32'd659255;
            6'd18: return 32'd698456;
            6'd19: return 32'd739989;
            6'd20: return 32'd783991;
            6'd21: return 32'd830609;
            6'd22: return 32'd880000;
            6'd23: return 32'd932328;
            6'd24: return 32'd987767;
            6'd25: return 32'd1046502;
            6'd26: return 32'd1108731;
            6'd27: return 32'd1174659;
            6'd28: return 32'd1244508;
            6'd29: return 32'd1318510;
            6'd30: return 32'd1396913;
            6'd31: return 32'd1479978;
            6'd32: return 32'd1567982;
            6'd33: return 32'd1661219;
            6'd34: return 32'd1760000;
            6'd35: return 32'd1864655;
            6'd36: return 32'd1975533;
            default: return 32'd0;
        endcase
    endfunction

    // Rounded clk_hz / f_note; only ever called with constant arguments so
    // the division is resolved at elaboration into a lookup table
    function automatic logic [DIVX_W-1:0] note_divx(input logic [NOTE_W-1:0] note,
                                                     input longint unsigned clk_hz);
        longint unsigned f;
        longint unsigned num;
        f = 64'(note_mhz(note));
        if (f == 64'd0) return '0;
        num = clk_hz * 64'd1000 + (f >> 1);
        return DIVX_W'(num / f);
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Front-panel controls and divider-side outputs of the note sequencer.
interface note_sequencer_if
    import note_sequencer_pkg::*;
();
    logic              play;
    logic              stop;
    logic              loop;
    logic [DIVX_W-1:0] divx;
    logic              mute;
    logic [NOTE_W-1:0] note_idx;
    logic              busy;
    logic              done;

    modport master (
        output play, stop, loop,
        input  divx, mute, note_idx, busy, done
    );

    modport slave (
        input  play, stop, loop,
        output divx, mute, note_idx, busy, done
    );
endinterface

// File: rtl/note_sequencer_song_rom.sv
// Synchronous-read melody ROM; contents arrive as a packed parameter with
// entry 0 in the least significant bits.
module song_rom
    import note_sequencer_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter logic [ENTRY_W*(2**ADDR_W)-1:0] SONG = '0
) (
    input  logic               clk,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [ENTRY_W-1:0] o_data
);

    logic [ENTRY_W-1:0] r_data;

    // One-cycle read latency: the entry addressed this cycle is visible next cycle
    always_ff @(posedge clk) begin
        r_data <= SONG[ENTRY_W*int'(i_addr) +: ENTRY_W];
    end

    assign o_data = r_data;

endmodule

// File: rtl/note_sequencer.sv
// Melody player: walks the song ROM, turns each entry into a divisor word
// and mute flag, times notes with a tick/beat counter and inserts a silent
// gap at the end of every note so repeated notes articulate.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 12_500_000,
    parameter int GAP_TICKS      = 1_250_000,
    parameter int CLK_HZ         = 50_000_000,
    parameter int ADDR_W         = 5,
    parameter logic [ENTRY_W*(2**ADDR_W)-1:0] SONG = (ENTRY_W*(2**ADDR_W))'(DEMO_SONG)
) (
    input  logic             clk,
    input  logic             rst,
    note_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(TICKS_PER_BEAT + 1);
    localparam logic [CNT_W-1:0] TICK_LAST      = CNT_W'(TICKS_PER_BEAT - 1);
    localparam logic [CNT_W-1:0] TICK_GAP_START = CNT_W'(TICKS_PER_BEAT - GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST       = CNT_W'(GAP_TICKS - 1);

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [ADDR_W:0]    r_addr;
    logic [ADDR_W:0]    w_addr_next;
    logic [BEATS_W-1:0] r_beat_cnt;
    logic [BEATS_W-1:0] w_beat_next;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic [CNT_W-1:0]   w_tick_next;
    logic [DIVX_W-1:0]  r_divx;
    logic [DIVX_W-1:0]  w_divx_next;
    logic               r_mute;
    logic               w_mute_next;
    logic [NOTE_W-1:0]  r_note_idx;
    logic [NOTE_W-1:0]  w_note_next;
    logic               r_busy;
    logic               r_done;
    logic               w_done_next;

    logic [ENTRY_W-1:0] w_rom_data;
    logic [NOTE_W-1:0]  w_note;
    logic [BEATS_W-1:0] w_beats;
    logic               w_song_end;
    logic [DIVX_W-1:0]  w_divx_tab [2**NOTE_W];

    // The extra address bit flags a walk past the last ROM entry
    song_rom #(
        .ADDR_W (ADDR_W),
        .SONG   (SONG)
    ) u_song_rom (
        .clk    (clk),
        .i_addr (r_addr[ADDR_W-1:0]),
        .o_data (w_rom_data)
    );

    assign w_note     = w_rom_data[ENTRY_W-1:BEATS_W];
    assign w_beats    = w_rom_data[BEATS_W-1:0];
    assign w_song_end = (w_beats == '0) || r_addr[ADDR_W];

    for (genvar g = 0; g < 2**NOTE_W; g++) begin : g_divx
        assign w_divx_tab[g] = note_divx(NOTE_W'(g), 64'(CLK_HZ));
    end

    // Next-state and next-output logic; stop beats play, play beats everything else
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_beat_next  = r_beat_cnt;
        w_tick_next  = r_tick_cnt;
        w_divx_next  = r_divx;
        w_mute_next  = r_mute;
        w_note_next  = r_note_idx;
        w_done_next  = 1'b0;

        if (bus.stop) begin
            w_state_next = ST_IDLE;
            w_addr_next  = '0;
            w_tick_next  = '0;
            w_mute_next  = 1'b1;
        end else if (bus.play) begin
            w_state_next = ST_FETCH;
            w_addr_next  = '0;
            w_tick_next  = '0;
            w_mute_next  = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_mute_next = 1'b1;
                end
                ST_FETCH: begin
                    w_state_next = ST_EVAL;
                end
                ST_EVAL: begin
                    if (w_song_end) begin
                        w_addr_next = '0;
                        if (bus.loop) begin
                            w_state_next = ST_FETCH;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_done_next  = 1'b1;
                        end
                    end else begin
                        w_note_next  = w_note;
                        w_mute_next  = (w_note == REST);
                        if (w_note != REST) begin
                            w_divx_next = w_divx_tab[w_note];
                        end
                        w_beat_next  = w_beats;
                        w_tick_next  = '0;
                        w_state_next = ST_NOTE;
                    end
                end
                ST_NOTE: begin
                    if (r_beat_cnt == BEATS_W'(1) && r_tick_cnt == TICK_GAP_START) begin
                        w_state_next = ST_GAP;
                        w_tick_next  = '0;
                        w_mute_next  = 1'b1;
                    end else if (r_tick_cnt == TICK_LAST) begin
                        w_tick_next = '0;
                        w_beat_next = r_beat_cnt - BEATS_W'(1);
                    end else begin
                        w_tick_next = r_tick_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    w_mute_next = 1'b1;
                    if (r_tick_cnt == GAP_LAST) begin
                        w_tick_next  = '0;
                        w_addr_next  = r_addr + (ADDR_W+1)'(1);
                        w_state_next = ST_FETCH;
                    end else begin
                        w_tick_next = r_tick_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_mute_next  = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs, cleared by the synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_beat_cnt <= '0;
            r_tick_cnt <= '0;
            r_divx     <= '0;
            r_mute     <= 1'b1;
            r_note_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_beat_cnt <= w_beat_next;
            r_tick_cnt <= w_tick_next;
            r_divx     <= w_divx_next;
            r_mute     <= w_mute_next;
            r_note_idx <= w_note_next;
            r_busy     <= (w_state_next != ST_IDLE);
            r_done     <= w_done_next;
        end
    end

    assign bus.divx     = r_divx;
    assign bus.mute     = r_mute;
    assign bus.note_idx = r_note_idx;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: short song {A4,2},{REST,1},{END} on one
// instance and a fully populated 32-entry song on a second instance.
module tb_note_sequencer;

    localparam int TPB     = 10;
    localparam int GAP     = 2;
    localparam int CLKHZ   = 50_000_000;
    localparam int A4_DIVX = 113636;

    localparam logic [287:0] SONG_SHORT = 288'({9'd0, 9'd1, 9'd82});

    function automatic logic [287:0] makeFullSong();
        logic [287:0] s;
        s = '0;
        for (int i = 0; i < 32; i++) begin
            s[9*i +: 9] = {6'(i + 1), 3'd1};
        end
        return s;
    endfunction

    localparam logic [287:0] SONG_FULL = makeFullSong();

    logic clk = 1'b0;
    logic rst;
    int   assertCount = 0;
    int   failCount   = 0;

    note_sequencer_if busA ();
    note_sequencer_if busB ();

    note_sequencer #(
        .TICKS_PER_BEAT (TPB),
        .GAP_TICKS      (GAP),
        .CLK_HZ         (CLKHZ),
        .ADDR_W         (5),
        .SONG           (SONG_SHORT)
    ) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    note_sequencer #(
        .TICKS_PER_BEAT (TPB),
        .GAP_TICKS      (GAP),
        .CLK_HZ         (CLKHZ),
        .ADDR_W         (5),
        .SONG           (SONG_FULL)
    ) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    // Free-running bench clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        busA.stop = 1'b1;
        tick();
        busA.stop = 1'b0;
        busA.loop = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        assertCount++; if (busA.divx !== 32'd0) begin failCount++; $display("[TB] FAIL reset_divx: got %0d expected 0", busA.divx); end
        assertCount++; if (busA.mute !== 1'b1) begin failCount++; $display("[TB] FAIL reset_mute: got %b expected 1", busA.mute); end
        assertCount++; if (busA.busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busA.busy); end
        assertCount++; if (busA.done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b expected 0", busA.done); end
        assertCount++; if (busA.note_idx !== 6'd0) begin failCount++; $display("[TB] FAIL reset_note_idx: got %0d expected 0", busA.note_idx); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_play();
        int lowRun;
        int highRun;
        logic [5:0]  restIdx;
        logic [31:0] restDivx;
        restIdx  = 6'h3F;
        restDivx = 32'd0;
        busA.play = 1'b1;
        tick();
        busA.play = 1'b0;
        assertCount++; if (busA.busy !== 1'b1) begin failCount++; $display("[TB] FAIL play_busy_rise: got %b expected 1", busA.busy); end
        assertCount++; if (busA.mute !== 1'b1) begin failCount++; $display("[TB] FAIL play_fetch_mute: got %b expected 1", busA.mute); end
        tick();
        tick();
        assertCount++; if (busA.divx !== 32'(A4_DIVX)) begin failCount++; $display("[TB] FAIL onset_divx: got %0d expected %0d", busA.divx, A4_DIVX); end
        assertCount++; if (busA.note_idx !== 6'd10) begin failCount++; $display("[TB] FAIL onset_note_idx: got %0d expected 10", busA.note_idx); end
        lowRun = 0;
        for (int i = 0; i < 60 && busA.mute === 1'b0; i++) begin
            lowRun++;
            tick();
        end
        assertCount++; if (lowRun != 18) begin failCount++; $display("[TB] FAIL a4_sound_cycles: got %0d expected 18", lowRun); end
        highRun = 0;
        for (int i = 0; i < 60 && busA.mute === 1'b1 && busA.done === 1'b0 && busA.busy === 1'b1; i++) begin
            if (highRun == 4) begin
                restIdx  = busA.note_idx;
                restDivx = busA.divx;
            end
            highRun++;
            tick();
        end
        assertCount++; if (highRun != 16) begin failCount++; $display("[TB] FAIL silent_cycles: got %0d expected 16", highRun); end
        assertCount++; if (restIdx !== 6'd0) begin failCount++; $display("[TB] FAIL rest_note_idx: got %0d expected 0", restIdx); end
        assertCount++; if (restDivx !== 32'(A4_DIVX)) begin failCount++; $display("[TB] FAIL rest_divx_hold: got %0d expected %0d", restDivx, A4_DIVX); end
        assertCount++; if (busA.done !== 1'b1) begin failCount++; $display("[TB] FAIL done_pulse: got %b expected 1", busA.done); end
        assertCount++; if (busA.busy !== 1'b0) begin failCount++; $display("[TB] FAIL done_busy_fall: got %b expected 0", busA.busy); end
        tick();
        assertCount++; if (busA.done !== 1'b0) begin failCount++; $display("[TB] FAIL done_one_cycle: got %b expected 0", busA.done); end
    endtask

    task automatic test_play_at_end();
        busA.play = 1'b1;
        tick();
        busA.play = 1'b0;
        repeat (35) tick();
        busA.play = 1'b1;
        tick();
        busA.play = 1'b0;
        assertCount++; if (busA.done !== 1'b0) begin failCount++; $display("[TB] FAIL play_at_end_done: got %b expected 0", busA.done); end
        assertCount++; if (busA.busy !== 1'b1) begin failCount++; $display("[TB] FAIL play_at_end_busy: got %b expected 1", busA.busy); end
        tick();
        tick();
        assertCount++; if (busA.mute !== 1'b0 || busA.note_idx !== 6'd10) begin failCount++; $display("[TB] FAIL play_at_end_onset: got mute %b idx %0d expected mute 0 idx 10", busA.mute, busA.note_idx); end
        quiesce();
    endtask

    task automatic test_loop();
        int   cnt;
        logic sawDone;
        busA.loop = 1'b1;
        busA.play = 1'b1;
        tick();
        busA.play = 1'b0;
        tick();
        tick();
        cnt = 0;
        sawDone = 1'b0;
        while (busA.mute === 1'b0 && cnt < 100) begin tick(); cnt++; sawDone |= busA.done; end
        while (busA.mute === 1'b1 && cnt < 100) begin tick(); cnt++; sawDone |= busA.done; end
        assertCount++; if (cnt != 36) begin failCount++; $display("[TB] FAIL loop_period: got %0d expected 36", cnt); end
        assertCount++; if (sawDone !== 1'b0) begin failCount++; $display("[TB] FAIL loop_no_done: got %b expected 0", sawDone); end
        assertCount++; if (busA.note_idx !== 6'd10 || busA.busy !== 1'b1) begin failCount++; $display("[TB] FAIL loop_reonset: got idx %0d busy %b expected idx 10 busy 1", busA.note_idx, busA.busy); end
        quiesce();
    endtask

    task automatic test_stop();
        busA.play = 1'b1;
        tick();
        busA.play = 1'b0;
        tick();
        tick();
        repeat (5) tick();
        busA.stop = 1'b1;
        tick();
        busA.stop = 1'b0;
        assertCount++; if (busA.mute !== 1'b1) begin failCount++; $display("[TB] FAIL stop_mute: got %b expected 1", busA.mute); end
        assertCount++; if (busA.busy !== 1'b0) begin failCount++; $display("[TB] FAIL stop_busy: got %b expected 0", busA.busy); end
        repeat (3) tick();
        assertCount++; if (busA.busy !== 1'b0 || busA.done !== 1'b0) begin failCount++; $display("[TB] FAIL stop_stays_idle: got busy %b done %b expected 0 0", busA.busy, busA.done); end
        busA.play = 1'b1;
        tick();
        busA.play = 1'b0;
        tick();
        tick();
        assertCount++; if (busA.mute !== 1'b0 || busA.note_idx !== 6'd10 || busA.divx !== 32'(A4_DIVX)) begin failCount++; $display("[TB] FAIL stop_replay: got mute %b idx %0d divx %0d expected 0 10 %0d", busA.mute, busA.note_idx, busA.divx, A4_DIVX); end
    endtask

    task automatic test_back_to_back();
        repeat (2) tick();
        busA.play = 1'b1;
        busA.stop = 1'b1;
        tick();
        busA.play = 1'b0;
        busA.stop = 1'b0;
        assertCount++; if (busA.busy !== 1'b0 || busA.mute !== 1'b1) begin failCount++; $display("[TB] FAIL play_stop_same: got busy %b mute %b expected 0 1", busA.busy, busA.mute); end
        tick();
        busA.play = 1'b1;
        tick();
        busA.play = 1'b0;
        tick();
        tick();
        repeat (4) tick();
        busA.play = 1'b1;
        tick();
        busA.play = 1'b0;
        assertCount++; if (busA.mute !== 1'b1 || busA.busy !== 1'b1) begin failCount++; $display("[TB] FAIL restart_cut: got mute %b busy %b expected 1 1", busA.mute, busA.busy); end
        tick();
        assertCount++; if (busA.mute !== 1'b1) begin failCount++; $display("[TB] FAIL restart_eval_mute: got %b expected 1", busA.mute); end
        tick();
        assertCount++; if (busA.mute !== 1'b0 || busA.note_idx !== 6'd10) begin failCount++; $display("[TB] FAIL restart_onset: got mute %b idx %0d expected 0 10", busA.mute, busA.note_idx); end
    endtask

    task automatic test_reset_mid_note();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        assertCount++; if (busA.divx !== 32'd0 || busA.note_idx !== 6'd0) begin failCount++; $display("[TB] FAIL midreset_values: got divx %0d idx %0d expected 0 0", busA.divx, busA.note_idx); end
        assertCount++; if (busA.mute !== 1'b1 || busA.busy !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_flags: got mute %b busy %b expected 1 0", busA.mute, busA.busy); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full_wrap();
        int          cnt;
        int          onsets;
        logic        prevMute;
        logic [5:0]  lastIdx;
        logic [31:0] a4Divx;
        busB.loop = 1'b0;
        busB.play = 1'b1;
        tick();
        busB.play = 1'b0;
        cnt = 0;
        onsets = 0;
        lastIdx = 6'd0;
        a4Divx = 32'd0;
        prevMute = busB.mute;
        while (busB.done !== 1'b1 && cnt < 1000) begin
            tick();
            cnt++;
            if (prevMute === 1'b1 && busB.mute === 1'b0) begin
                onsets++;
                lastIdx = busB.note_idx;
                if (busB.note_idx == 6'd10) a4Divx = busB.divx;
            end
            prevMute = busB.mute;
        end
        assertCount++; if (cnt != 386) begin failCount++; $display("[TB] FAIL wrap_done_time: got %0d expected 386", cnt); end
        assertCount++; if (onsets != 32) begin failCount++; $display("[TB] FAIL wrap_onsets: got %0d expected 32", onsets); end
        assertCount++; if (lastIdx !== 6'd32) begin failCount++; $display("[TB] FAIL wrap_last_note: got %0d expected 32", lastIdx); end
        assertCount++; if (a4Divx !== 32'(A4_DIVX)) begin failCount++; $display("[TB] FAIL wrap_a4_divx: got %0d expected %0d", a4Divx, A4_DIVX); end
        assertCount++; if (busB.busy !== 1'b0) begin failCount++; $display("[TB] FAIL wrap_busy: got %b expected 0", busB.busy); end
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b0;
        busA.play = 1'b0; busA.stop = 1'b0; busA.loop = 1'b0;
        busB.play = 1'b0; busB.stop = 1'b0; busB.loop = 1'b0;
        test_reset();
        test_single_play();
        quiesce();
        test_play_at_end();
        test_loop();
        test_stop();
        test_back_to_back();
        test_reset_mid_note();
        quiesce();
        test_full_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global time limit so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Tune player that sits directly upstream of the clock divider in the piano datapath. It steps through a melody stored in a small ROM and converts each entry into a divisor word (`divx`) and a `mute` flag for the divider and the output gate. Note length comes from a tempo tick counter, and a short silent gap is inserted between notes so repeated notes articulate. Start, stop and loop are driven by front-panel strobes.

## Interface
Parameters:
- `TICKS_PER_BEAT`, default 12_500_000: clk cycles per beat (250 ms at 50 MHz).
- `GAP_TICKS`, default 1_250_000: silent cycles at the end of each note. Legal range is 1 ≤ GAP_TICKS < TICKS_PER_BEAT.
- `CLK_HZ`, default 50_000_000: system clock frequency, used by the note divisor table.
- `ADDR_W`, default 5: ROM address width. SONG_LEN = 2**ADDR_W.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `play`  in  1: single-cycle strobe; (re)start the song from address 0.
- `stop`  in  1: single-cycle strobe; abort playback.
- `loop`  in  1: level; when 1, restart at address 0 on end-of-song.
- `divx`  out  32: divisor word for the downstream clock divider.
- `mute`  out  1: 1 = output must be silent.
- `note_idx`  out  6: index of the current note, for the display.
- `busy`  out  1: 1 while any state other than IDLE is active.
- `done`  out  1: one-cycle pulse on non-looping end-of-song.

## Operation
- ROM entry is 9 bits: `{note[5:0], beats[2:0]}`.
  - note 0 = rest. Notes 1..36 = C4..B6, chromatic, so A4 = 10.
  - beats = 0 marks end-of-song.
- FSM states: IDLE, FETCH, EVAL, NOTE, GAP.
- IDLE: mute=1, busy=0. On `play` go to FETCH with addr=0.
- FETCH: present addr to the synchronous ROM (1-cycle read latency). Go to EVAL.
- EVAL, end case: if beats==0, or addr wrapped past SONG_LEN-1:
  - loop=1: set addr=0 and go to FETCH.
  - loop=0: pulse `done` and go to IDLE.
- EVAL, normal case:
  - Register divx = note_divx(note), note_idx = note, mute = (note==0).
  - Load beat_cnt = beats and tick_cnt = 0, then go to NOTE.
  - For a rest, divx holds its previous value.
- NOTE: tick_cnt counts 0..TICKS_PER_BEAT-1; each wrap decrements beat_cnt.
  - When beat_cnt==1 and tick_cnt == TICKS_PER_BEAT-GAP_TICKS-1, go to GAP.
- GAP: mute=1 and divx held. After GAP_TICKS cycles, addr+1 and go to FETCH.
- Divisor: note_divx = round(CLK_HZ / f_note), 32-bit unsigned, from a constant table (A4 → 113636 at 50 MHz).
- `stop` in any state: go to IDLE on the next edge, mute=1, addr=0.
- `stop` and `play` in the same cycle: stop wins.
- `play` while busy: restart at addr 0 through FETCH. The current note is cut and mute=1 from the next edge.
- `play` in the same cycle as an EVAL end-of-song: play wins, no `done` pulse.

## Timing
- Reset values: divx=0, mute=1, note_idx=0, busy=0, done=0, state=IDLE, addr=0, all counters 0.
- All outputs are registered.
- `play` at edge N:
  - busy=1 after edge N+1.
  - divx/mute/note_idx valid after edge N+3.
- Per entry with beats=b:
  - sounding time: b·TICKS_PER_BEAT − GAP_TICKS cycles, mute=0.
  - gap: GAP_TICKS cycles, mute=1.
  - fetch overhead: 2 cycles, mute=1 (FETCH, EVAL).
- A rest entry is muted for b·TICKS_PER_BEAT cycles (its gap merges into the silence), plus 2 fetch cycles.
- `done` is high for exactly the one cycle after EVAL detects the end. busy falls on the same edge.
- Reset asserted mid-note: all outputs return to reset values on that edge.

## Structure
- Shared package/header `piano_pkg`:
  - note index constants (REST=0, C4=1, A4=10, ...)
  - `note_divx` constant function / table
  - ROM entry field widths
  - FSM state encoding
- Sub-module `song_rom`: synchronous-read ROM, ADDR_W address, 9-bit data, init from a hex file. It is shared with the display block.

## Test plan
Bench parameters: TICKS_PER_BEAT=10, GAP_TICKS=2, CLK_HZ=50_000_000.

1. Reset: rst=0 for 3 cycles → divx=0, mute=1, busy=0, done=0.
2. ROM {A4,2},{REST,1},{END}, play at edge 0:
   - after edge 3: divx=113636, note_idx=10, mute=0 for 18 cycles.
   - then mute=1 for 2 (gap) + 2 (fetch) + 10 (rest) + 2 (fetch) cycles.
   - then `done` high 1 cycle, busy=0.
3. Same ROM with loop=1 → no done pulse; A4 resounds 36 cycles after first onset (period = 18+2+2+10+2+2).
4. stop asserted 5 cycles into A4 → mute=1 on the next edge, busy=0; a later play restarts at addr 0.
5. play and stop in the same cycle while playing → IDLE. play alone mid-note → restart, with A4 onset 3 edges later.
6. ROM fully populated (no END marker), loop=0 → after entry 31 the address wrap ends the song with a done pulse.
